// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive-side frame parser.
package uart_pkg;

    // Frame start marker used when the instantiating design does not override it.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Inter-byte idle allowance: 1 ms at 50 MHz.
    localparam int TIMEOUT_CYC_DEF = 50000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DONE    = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: synchronous write, combinational read, never cleared.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_50m,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    // Payload byte write; contents deliberately survive reset.
    always_ff @(posedge clk_50m) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Receive-side frame parser: SYNC-LEN-PAYLOAD-CSUM frames from the UART byte
// handshake into a local buffer, held for the host until acknowledged.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                         clk_50m,
    input  logic                         rst,
    input  logic                         rx_rdy,
    input  logic [7:0]                   rx_data,
    output logic                         rx_rdy_clr,
    output logic                         frm_valid,
    output logic [$clog2(MAX_LEN+1)-1:0] frm_len,
    input  logic [$clog2(MAX_LEN)-1:0]   frm_rd_addr,
    output logic [7:0]                   frm_rd_data,
    input  logic                         frm_ack,
    output logic                         frm_busy,
    output logic                         err_csum,
    output logic                         err_len,
    output logic                         err_timeout
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    rx_state_e     state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          clr_q, clr_d;
    logic          frm_valid_q, frm_valid_d;
    logic [LW-1:0] frm_len_q, frm_len_d;
    logic          err_csum_q, err_csum_d;
    logic          err_len_q, err_len_d;
    logic          err_tmo_q, err_tmo_d;

    logic          accept;
    logic          busy;
    logic          len_bad;
    logic [7:0]    sum_add;
    logic [LW-1:0] idx_inc;
    logic          buf_we;

    // The cycle after an accept rx_rdy is still high while the UART clears it,
    // so clr_q blocks a second take of the same byte. DONE back-pressures.
    assign accept  = rx_rdy && !clr_q && (state_q != ST_DONE);
    assign busy    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    assign len_bad = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign sum_add = sum_q + rx_data;
    assign idx_inc = idx_q + LW'(1);

    // State and datapath registers; buffer excluded so it is not cleared.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            clr_q       <= 1'b0;
            frm_valid_q <= 1'b0;
            frm_len_q   <= '0;
            err_csum_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            clr_q       <= clr_d;
            frm_valid_q <= frm_valid_d;
            frm_len_q   <= frm_len_d;
            err_csum_q  <= err_csum_d;
            err_len_q   <= err_len_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    // Next-state, checksum, buffer write and inter-byte timeout.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        tmo_d       = '0;
        clr_d       = accept;
        frm_valid_d = frm_valid_q;
        frm_len_d   = frm_len_q;
        err_csum_d  = 1'b0;
        err_len_d   = 1'b0;
        err_tmo_d   = 1'b0;
        buf_we      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (len_bad) begin
                        err_len_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        len_d   = rx_data[LW-1:0];
                        idx_d   = '0;
                        sum_d   = rx_data;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    buf_we = 1'b1;
                    sum_d  = sum_add;
                    idx_d  = idx_inc;
                    if (idx_inc == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (sum_add == 8'd0) begin
                        frm_valid_d = 1'b1;
                        frm_len_d   = len_q;
                        state_d     = ST_DONE;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (frm_ack) begin
                    frm_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accepted byte restarts the count and wins over an expiring timer.
        // Every entry into a busy state happens on an accept or from IDLE,
        // both of which leave the counter at zero.
        if (busy && !accept) begin
            if (tmo_q == TMO_LAST) begin
                err_tmo_d = 1'b1;
                state_d   = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_50m (clk_50m),
        .we      (buf_we),
        .waddr   (idx_q[AW-1:0]),
        .wdata   (rx_data),
        .raddr   (frm_rd_addr),
        .rdata   (frm_rd_data)
    );

    assign rx_rdy_clr  = clr_q;
    assign frm_valid   = frm_valid_q;
    assign frm_len     = frm_len_q;
    assign frm_busy    = busy;
    assign err_csum    = err_csum_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus pushes expected events, a
// negedge monitor pops and compares frames and error pulses.
`timescale 1ns/100ps
module tb_uart_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 300;

    localparam int EV_FRAME = 0;
    localparam int EV_CSUM  = 1;
    localparam int EV_LEN   = 2;
    localparam int EV_TMO   = 3;

    typedef struct {
        int           kind;
        int           len;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   clr_cnt = 0;

    logic       clk_50m = 1'b0;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy_clr;
    logic       frm_valid;
    logic [4:0] frm_len;
    logic [3:0] frm_rd_addr = '0;
    logic [7:0] frm_rd_data;
    logic       frm_ack;
    logic       frm_busy;
    logic       err_csum;
    logic       err_len;
    logic       err_timeout;

    uart_frame_rx #(
        .MAX_LEN     (MAX_LEN),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .rx_rdy_clr  (rx_rdy_clr),
        .frm_valid   (frm_valid),
        .frm_len     (frm_len),
        .frm_rd_addr (frm_rd_addr),
        .frm_rd_data (frm_rd_data),
        .frm_ack     (frm_ack),
        .frm_busy    (frm_busy),
        .err_csum    (err_csum),
        .err_len     (err_len),
        .err_timeout (err_timeout)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int len = 0, input logic [127:0] d = '0);
        exp_t e;
        e.kind = kind;
        e.len  = len;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor side: one pop per observed event.
    task automatic observe(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_FRAME && e.kind == EV_FRAME) begin
                chk("frm_len", 32'(frm_len), e.len);
                for (int i = 0; i < e.len; i++) begin
                    frm_rd_addr = 4'(i);
                    #0.5;
                    chk($sformatf("frm_data[%0d]", i), 32'(frm_rd_data), 32'(e.data[8*i +: 8]));
                end
            end
        end
    endtask

    logic prev_v = 1'b0;
    always @(negedge clk_50m) begin
        if (rx_rdy_clr) clr_cnt++;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (err_csum)    observe(EV_CSUM);
            if (err_len)     observe(EV_LEN);
            if (err_timeout) observe(EV_TMO);
            if (frm_valid && !prev_v) observe(EV_FRAME);
            prev_v = frm_valid;
        end
    end

    // UART model: hold rdy with data until the clear pulse shows up.
    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(posedge clk_50m);
            #1;
            if (rx_rdy_clr) got = 1;
        end
        rx_rdy = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte %0h not taken within 50 cycles", b);
        end
    endtask

    task automatic send_bytes(input int n, input logic [127:0] b);
        for (int i = 0; i < n; i++) send_byte(b[8*i +: 8]);
    endtask

    task automatic ack_frame(input string name);
        frm_ack = 1'b1;
        @(posedge clk_50m);
        #1;
        frm_ack = 1'b0;
        chk(name, 32'(frm_valid), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_50m);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst     = 1'b1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        frm_ack = 1'b0;
        #5;
        chk("rst_clr",   32'(rx_rdy_clr), 0);
        chk("rst_valid", 32'(frm_valid), 0);
        chk("rst_len",   32'(frm_len), 0);
        chk("rst_busy",  32'(frm_busy), 0);
        chk("rst_errs",  32'({err_csum, err_len, err_timeout}), 0);
        idle(3);
        rst = 1'b0;
        idle(1);

        // Good frame, six bytes consumed.
        c0 = clr_cnt;
        push_ev(EV_FRAME, 3, {8'h33, 8'h22, 8'h11});
        send_bytes(6, {8'h97, 8'h33, 8'h22, 8'h11, 8'h03, 8'hA5});
        chk("a_valid", 32'(frm_valid), 1);
        chk("a_len",   32'(frm_len), 3);
        idle(3);
        chk("a_clr_pulses", clr_cnt - c0, 6);
        ack_frame("a_ack");

        // Bad checksum, then a one-byte frame.
        push_ev(EV_CSUM);
        send_bytes(6, {8'h96, 8'h33, 8'h22, 8'h11, 8'h03, 8'hA5});
        idle(3);
        chk("csum_no_valid", 32'(frm_valid), 0);
        push_ev(EV_FRAME, 1, {8'h7F});
        send_bytes(4, {8'h80, 8'h7F, 8'h01, 8'hA5});
        chk("b_valid", 32'(frm_valid), 1);
        idle(3);
        ack_frame("b_ack");

        // Garbage, zero length, oversize length.
        push_ev(EV_LEN);
        send_bytes(5, {8'h00, 8'hA5, 8'h5A, 8'hFF, 8'h00});
        push_ev(EV_LEN);
        send_bytes(2, {8'h11, 8'hA5});
        idle(3);
        chk("len_idle", 32'(frm_busy), 0);

        // Inter-byte timeout: fires exactly TMO cycles after the last accept.
        push_ev(EV_TMO);
        send_bytes(3, {8'h10, 8'h02, 8'hA5});
        idle(TMO - 1);
        chk("tmo_not_early_busy", 32'(frm_busy), 1);
        chk("tmo_not_early_err",  32'(err_timeout), 0);
        idle(1);
        chk("tmo_pulse", 32'(err_timeout), 1);
        chk("tmo_idle",  32'(frm_busy), 0);
        idle(2);
        push_ev(EV_FRAME, 2, {8'h20, 8'h10});
        send_bytes(5, {8'hCE, 8'h20, 8'h10, 8'h02, 8'hA5});
        chk("c_valid", 32'(frm_valid), 1);
        chk("c_len",   32'(frm_len), 2);
        idle(3);
        ack_frame("c_ack");

        // Held frame back-pressures; byte taken only after the ack cycle.
        push_ev(EV_FRAME, 1, {8'h7F});
        send_bytes(4, {8'h80, 8'h7F, 8'h01, 8'hA5});
        rx_data = 8'h00;
        rx_rdy  = 1'b1;
        idle(1);
        c0 = clr_cnt;
        idle(100);
        chk("hold_no_clr", clr_cnt - c0, 0);
        chk("hold_valid",  32'(frm_valid), 1);
        ack_frame("hold_ack");
        chk("hold_ack_no_take", 32'(rx_rdy_clr), 0);
        idle(1);
        chk("hold_take_after", 32'(rx_rdy_clr), 1);
        rx_rdy = 1'b0;
        idle(3);

        // Async reset mid-payload; frm_len from the last frame must clear too.
        send_bytes(4, {8'h02, 8'h01, 8'h04, 8'hA5});
        #4;
        rst = 1'b1;
        #1;
        chk("mid_rst_clr",   32'(rx_rdy_clr), 0);
        chk("mid_rst_busy",  32'(frm_busy), 0);
        chk("mid_rst_len",   32'(frm_len), 0);
        chk("mid_rst_valid", 32'(frm_valid), 0);
        chk("mid_rst_errs",  32'({err_csum, err_len, err_timeout}), 0);
        repeat (2) @(posedge clk_50m);
        #3;
        rst = 1'b0;
        idle(1);
        push_ev(EV_FRAME, 1, {8'h55});
        send_bytes(4, {8'hAA, 8'h55, 8'h01, 8'hA5});
        chk("d_valid", 32'(frm_valid), 1);
        chk("d_len",   32'(frm_len), 1);
        idle(3);
        ack_frame("d_ack");

        idle(5);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
